// File: rtl/index_interp_pkg.sv
// Shared definitions for the table-interpolation correction block:
// FSM encoding, table base bits, step shifts, clamp and saturation limits.
package index_interp_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_R_A0   = 4'd1,
    ST_R_A1   = 4'd2,
    ST_R_WAIT = 4'd3,
    ST_R_MUL  = 4'd4,
    ST_R_ACC  = 4'd5,
    ST_P_A0   = 4'd6,
    ST_P_A1   = 4'd7,
    ST_P_WAIT = 4'd8,
    ST_P_MUL  = 4'd9,
    ST_P_ACC  = 4'd10,
    ST_OUT    = 4'd11
  } state_t;

  // Upper address bit selects the rise or pulse half of the table RAM
  localparam logic RISE_BASE  = 1'b0;
  localparam logic PULSE_BASE = 1'b1;

  // Step = 1 << shift
  localparam logic [2:0] RISE_SHIFT_NARROW  = 3'd6;
  localparam logic [2:0] PULSE_SHIFT_NARROW = 3'd5;
  localparam logic [2:0] SHIFT_WIDE         = 3'd7;

  // Highest index whose neighbour (idx+1) is still inside an 11-bit table half
  localparam logic [10:0] IDX_MAX = 11'h7FE;

  localparam int signed SAT_MAX = 32767;
  localparam int signed SAT_MIN = -32768;

  // Residual must stay strictly below the step
  function automatic logic [15:0] clamp_rem(input logic [15:0] rem, input logic [2:0] shift);
    logic [15:0] step;
    step = 16'd1 << shift;
    return (rem >= step) ? (step - 16'd1) : rem;
  endfunction

  function automatic logic [10:0] clamp_idx(input logic [15:0] idx);
    return (idx > {5'd0, IDX_MAX}) ? IDX_MAX : idx[10:0];
  endfunction

endpackage

// File: rtl/lin_interp.sv
// One-dimensional linear interpolation between two table entries:
// interp = e0 + ((e1 - e0) * remain >>> shift). The product is registered
// so the multiply and the final add sit in separate FSM cycles.
module lin_interp
  import index_interp_pkg::*;
(
  input  logic                     i_clk_50m,
  input  logic                     i_rst_n,
  input  logic                     i_mul_en,
  input  logic signed [DATA_W-1:0] i_e0,
  input  logic signed [DATA_W-1:0] i_e1,
  input  logic        [15:0]       i_remain,
  input  logic        [2:0]        i_shift,
  output logic signed [17:0]       o_interp
);

  logic signed [16:0] w_diff;
  logic signed [32:0] w_prod;
  logic signed [32:0] r_prod_p0;
  logic signed [32:0] w_scaled;

  assign w_diff = $signed({i_e1[15], i_e1}) - $signed({i_e0[15], i_e0});
  assign w_prod = $signed({{16{w_diff[16]}}, w_diff}) * $signed({17'd0, i_remain});

  // Product register, loaded in the *_MUL cycle
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n)
      r_prod_p0 <= '0;
    else if (i_mul_en)
      r_prod_p0 <= w_prod;
  end

  // --- stage p1: scale by the step and add back the base entry ---
  assign w_scaled = r_prod_p0 >>> i_shift;
  assign o_interp = $signed({{2{i_e0[15]}}, i_e0}) + $signed(w_scaled[17:0]);

endmodule

// File: rtl/index_interp.sv
// Index interpolation correction: on a done-flag edge, reads two neighbouring
// entries from the rise and pulse tables, interpolates each by its residual,
// and emits the saturated sum as a one-cycle result strobe.
module index_interp
  import index_interp_pkg::*;
(
  input  logic                     i_clk_50m,
  input  logic                     i_rst_n,
  input  logic        [3:0]        i_index_flag,
  input  logic        [15:0]       i_rise_index,
  input  logic        [15:0]       i_rise_remain,
  input  logic        [15:0]       i_pulse_index,
  input  logic        [15:0]       i_pulse_remain,
  output logic                     o_rd_en,
  output logic        [11:0]       o_rd_addr,
  input  logic signed [DATA_W-1:0] i_rd_data,
  output logic                     o_comp_valid,
  output logic signed [DATA_W-1:0] o_comp_value,
  output logic                     o_comp_err
);

  state_t r_state;
  state_t w_next;

  logic r_flag3_d;
  logic r_armed;
  logic r_go;
  logic w_trig;

  logic        r_err;
  logic [2:0]  r_rshift;
  logic [2:0]  r_pshift;
  logic [10:0] r_ridx;
  logic [10:0] r_pidx;
  logic [15:0] r_rrem;
  logic [15:0] r_prem;

  logic signed [DATA_W-1:0] r_e0;
  logic signed [DATA_W-1:0] r_e1;
  logic signed [17:0]       r_rise_val;
  logic signed [17:0]       r_pulse_val;
  logic signed [17:0]       w_interp;
  logic signed [18:0]       w_sum;

  logic        w_pulse_phase;
  logic        w_mul_en;
  logic [2:0]  w_shift;
  logic [15:0] w_rem;
  logic        w_rd_en_nxt;
  logic [11:0] w_rd_addr_nxt;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [18:0] v);
    if (v > SAT_MAX)
      return SAT_MAX[15:0];
    else if (v < SAT_MIN)
      return SAT_MIN[15:0];
    else
      return v[15:0];
  endfunction

  // A job may only start from IDLE, once the flag has been seen low after reset
  assign w_trig = (r_state == ST_IDLE) & ~r_go & r_armed
                & i_index_flag[3] & ~r_flag3_d;

  // Edge detector, post-reset arming and the start cycle of a valid job
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flag3_d <= 1'b0;
      r_armed   <= 1'b0;
      r_go      <= 1'b0;
    end else begin
      r_flag3_d <= i_index_flag[3];
      r_armed   <= r_armed | ~i_index_flag[3];
      r_go      <= w_trig & ~i_index_flag[0];
    end
  end

  // Latch the job parameters on the trigger edge, already clamped to the step/table
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err    <= 1'b0;
      r_rshift <= '0;
      r_pshift <= '0;
      r_ridx   <= '0;
      r_pidx   <= '0;
      r_rrem   <= '0;
      r_prem   <= '0;
    end else if (w_trig) begin
      r_err    <= i_index_flag[0];
      r_rshift <= i_index_flag[2] ? SHIFT_WIDE : RISE_SHIFT_NARROW;
      r_pshift <= i_index_flag[1] ? SHIFT_WIDE : PULSE_SHIFT_NARROW;
      r_ridx   <= clamp_idx(i_rise_index);
      r_pidx   <= clamp_idx(i_pulse_index);
      r_rrem   <= clamp_rem(i_rise_remain,
                            i_index_flag[2] ? SHIFT_WIDE : RISE_SHIFT_NARROW);
      r_prem   <= clamp_rem(i_pulse_remain,
                            i_index_flag[1] ? SHIFT_WIDE : PULSE_SHIFT_NARROW);
    end
  end

  // State register
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state: fixed one-cycle walk through the rise then pulse phases
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_go)
          w_next = ST_R_A0;
        else if (w_trig & i_index_flag[0])
          w_next = ST_OUT;
      end
      ST_R_A0:   w_next = ST_R_A1;
      ST_R_A1:   w_next = ST_R_WAIT;
      ST_R_WAIT: w_next = ST_R_MUL;
      ST_R_MUL:  w_next = ST_R_ACC;
      ST_R_ACC:  w_next = ST_P_A0;
      ST_P_A0:   w_next = ST_P_A1;
      ST_P_A1:   w_next = ST_P_WAIT;
      ST_P_WAIT: w_next = ST_P_MUL;
      ST_P_MUL:  w_next = ST_P_ACC;
      ST_P_ACC:  w_next = ST_OUT;
      ST_OUT:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Read strobe/address for the upcoming state, so they are registered outputs
  always_comb begin
    w_rd_en_nxt   = 1'b0;
    w_rd_addr_nxt = o_rd_addr;
    case (w_next)
      ST_R_A0: begin
        w_rd_en_nxt   = 1'b1;
        w_rd_addr_nxt = {RISE_BASE, r_ridx};
      end
      ST_R_A1: begin
        w_rd_en_nxt   = 1'b1;
        w_rd_addr_nxt = {RISE_BASE, r_ridx + 11'd1};
      end
      ST_P_A0: begin
        w_rd_en_nxt   = 1'b1;
        w_rd_addr_nxt = {PULSE_BASE, r_pidx};
      end
      ST_P_A1: begin
        w_rd_en_nxt   = 1'b1;
        w_rd_addr_nxt = {PULSE_BASE, r_pidx + 11'd1};
      end
      default: ;
    endcase
  end

  // RAM interface registers; address holds whenever the strobe is low
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_en   <= 1'b0;
      o_rd_addr <= '0;
    end else begin
      o_rd_en <= w_rd_en_nxt;
      if (w_rd_en_nxt)
        o_rd_addr <= w_rd_addr_nxt;
    end
  end

  // Entries arrive one cycle after their read; capture e0, e1, then the phase result
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_e0        <= '0;
      r_e1        <= '0;
      r_rise_val  <= '0;
      r_pulse_val <= '0;
    end else begin
      case (r_state)
        ST_R_A1, ST_P_A1:     r_e0        <= i_rd_data;
        ST_R_WAIT, ST_P_WAIT: r_e1        <= i_rd_data;
        ST_R_ACC:             r_rise_val  <= w_interp;
        ST_P_ACC:             r_pulse_val <= w_interp;
        default: ;
      endcase
    end
  end

  // One interpolator serves both phases; the phase picks residual and shift
  assign w_pulse_phase = (r_state == ST_P_MUL) | (r_state == ST_P_ACC);
  assign w_mul_en      = (r_state == ST_R_MUL) | (r_state == ST_P_MUL);
  assign w_shift       = w_pulse_phase ? r_pshift : r_rshift;
  assign w_rem         = w_pulse_phase ? r_prem   : r_rrem;

  lin_interp u_lin_interp (
    .i_clk_50m (i_clk_50m),
    .i_rst_n   (i_rst_n),
    .i_mul_en  (w_mul_en),
    .i_e0      (r_e0),
    .i_e1      (r_e1),
    .i_remain  (w_rem),
    .i_shift   (w_shift),
    .o_interp  (w_interp)
  );

  assign w_sum = $signed({r_rise_val[17], r_rise_val}) + $signed({r_pulse_val[17], r_pulse_val});

  // Result strobe and held result, updated only when OUT is reached
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_comp_valid <= 1'b0;
      o_comp_value <= '0;
      o_comp_err   <= 1'b0;
    end else begin
      o_comp_valid <= (r_state == ST_OUT);
      if (r_state == ST_OUT) begin
        o_comp_err   <= r_err;
        o_comp_value <= r_err ? '0 : sat16(w_sum);
      end
    end
  end

endmodule

// File: tb/tb_index_interp.sv
// Bench for index_interp: table RAM model, behavioural result model with a
// per-cycle scoreboard, and directed jobs with hand-computed results.
module tb_index_interp;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic               rst_n = 1'b0;
  logic [3:0]         flag  = 4'b0000;
  logic [15:0]        ridx  = '0;
  logic [15:0]        rrem  = '0;
  logic [15:0]        pidx  = '0;
  logic [15:0]        prem  = '0;
  logic               rd_en;
  logic [11:0]        rd_addr;
  logic signed [15:0] rd_data = '0;
  logic               vld;
  logic signed [15:0] val;
  logic               err;

  index_interp dut (
    .i_clk_50m      (clk),
    .i_rst_n        (rst_n),
    .i_index_flag   (flag),
    .i_rise_index   (ridx),
    .i_rise_remain  (rrem),
    .i_pulse_index  (pidx),
    .i_pulse_remain (prem),
    .o_rd_en        (rd_en),
    .o_rd_addr      (rd_addr),
    .i_rd_data      (rd_data),
    .o_comp_valid   (vld),
    .o_comp_value   (val),
    .o_comp_err     (err)
  );

  // Table RAM: one-cycle read latency
  logic signed [15:0] mem [0:4095];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int due;
    int value;
    int err;
  } exp_t;

  exp_t        sb[$];
  int          held_val  = 0;
  int          held_err  = 0;
  int          last_addr = 0;
  int          rd_log[$];
  bit          exp_v;

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // ---- behavioural model ----
  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int interp1(input int base, input int idx, input int rem, input int step);
    int e0, e1, i, r;
    i  = (idx > 2046) ? 2046 : idx;
    r  = (rem >= step) ? step - 1 : rem;
    e0 = mem[base + i];
    e1 = mem[base + i + 1];
    return e0 + floor_div((e1 - e0) * r, step);
  endfunction

  function automatic int model(input logic [3:0] f, input int ri, input int rr,
                               input int pi, input int pr);
    int s;
    if (f[0]) return 0;
    s = interp1(0, ri, rr, f[2] ? 128 : 64) + interp1(2048, pi, pr, f[1] ? 128 : 32);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  // Per-cycle compare against the scoreboard, sampled 2 ns after the rising edge
  always @(posedge clk) begin
    #2;
    exp_v = (sb.size() > 0) && (sb[0].due == cyc);
    chk("valid", int'(vld), int'(exp_v));
    if (exp_v) begin
      held_val = sb[0].value;
      held_err = sb[0].err;
      void'(sb.pop_front());
    end
    chk("value", int'(val), held_val);
    chk("err", int'(err), held_err);
    if (rd_en) begin
      rd_log.push_back(int'(rd_addr));
      last_addr = int'(rd_addr);
    end else begin
      chk("addr_hold", int'(rd_addr), last_addr);
    end
  end

  // Launch a job at a falling edge; detection happens on the next rising edge
  task automatic launch(input logic [3:0] f, input int ri, input int rr, input int pi,
                        input int pr, output int t0);
    exp_t e;
    @(negedge clk);
    ridx = 16'(ri); rrem = 16'(rr); pidx = 16'(pi); prem = 16'(pr);
    flag = f;
    t0 = cyc + 1;
    e.due   = t0 + (f[0] ? 1 : 12);
    e.value = model(f, ri, rr, pi, pr);
    e.err   = int'(f[0]);
    rd_log.delete();
    sb.push_back(e);
    @(negedge clk);
    flag[3] = 1'b0;
  endtask

  task automatic run_job(input logic [3:0] f, input int ri, input int rr, input int pi,
                         input int pr, input int lit, input bit busy_poke);
    int t0, ra, pa;
    launch(f, ri, rr, pi, pr, t0);
    if (busy_poke) begin
      repeat (3) @(negedge clk);
      ridx = 16'h0123; rrem = 16'h0011; pidx = 16'h0456; prem = 16'h0022;
      flag = 4'b1001;
      @(negedge clk);
      flag = 4'b0000;
    end
    for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      chk("valid_timeout", 1, 0);
      sb.delete();
    end
    chk("lit_value", int'(val), lit);
    chk("lit_err", int'(err), int'(f[0]));
    chk("num_reads", rd_log.size(), f[0] ? 0 : 4);
    if (!f[0] && rd_log.size() == 4) begin
      ra = (ri > 2046) ? 2046 : ri;
      pa = (pi > 2046) ? 2046 : pi;
      chk("rd_addr_r0", rd_log[0], ra);
      chk("rd_addr_r1", rd_log[1], ra + 1);
      chk("rd_addr_p0", rd_log[2], 2048 + pa);
      chk("rd_addr_p1", rd_log[3], 2048 + pa + 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int t0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    // Reset with the trigger flag already high: it must not start a job
    flag = 4'b1000;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(vld), 0);
    chk("rst_value", int'(val), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    flag = 4'b0000;
    repeat (2) @(negedge clk);

    // rise 100->200 at rem 32/64 = 150, pulse -50 at rem 0: total 100
    mem[12'h00A] = 16'sd100; mem[12'h00B] = 16'sd200;
    mem[12'h803] = -16'sd50; mem[12'h804] = 16'sd77;
    run_job(4'b1000, 10, 32, 3, 0, 100, 1'b0);

    // wide steps: rise 0->128 at 64/128 = 64, pulse 0->128 at 96/128 = 96
    mem[20] = 16'sd0; mem[21] = 16'sd128;
    mem[12'h828] = 16'sd0; mem[12'h829] = 16'sd128;
    run_job(4'b1110, 20, 64, 40, 96, 160, 1'b0);

    // invalid flag: immediate error result, no reads
    run_job(4'b1001, 10, 32, 3, 0, 0, 1'b0);

    // positive and negative saturation
    mem[100] = 16'sd30000; mem[101] = 16'sd30000;
    mem[12'h864] = 16'sd30000; mem[12'h865] = 16'sd30000;
    run_job(4'b1000, 100, 0, 100, 0, 32767, 1'b0);
    mem[100] = -16'sd30000; mem[101] = -16'sd30000;
    mem[12'h864] = -16'sd30000; mem[12'h865] = -16'sd30000;
    run_job(4'b1000, 100, 0, 100, 0, -32768, 1'b0);

    // index 0x900 clamps to 0x7FE, rem 200 clamps to 63: 6400*63/64 = 6300
    mem[12'h7FE] = 16'sd0; mem[12'h7FF] = 16'sd6400;
    mem[12'h800] = 16'sd0; mem[12'h801] = 16'sd0;
    run_job(4'b1000, 16'h900, 200, 0, 0, 6300, 1'b0);

    // negative slopes round toward -inf: 10+floor(-85/64)=8, 0+floor(-31/32)=-1
    // a second trigger mid-job must be ignored
    mem[30] = 16'sd10; mem[31] = -16'sd7;
    mem[12'h832] = 16'sd0; mem[12'h833] = -16'sd1;
    run_job(4'b1000, 30, 5, 50, 33, 7, 1'b1);

    // Reset in P_MUL aborts the job without a result
    launch(4'b1000, 10, 32, 3, 0, t0);
    for (int i = 0; i < 20 && cyc != t0 + 9; i++) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    held_val = 0; held_err = 0; last_addr = 0;
    rd_log.delete();
    #1;
    chk("async_rst_rd_addr", int'(rd_addr), 0);
    chk("async_rst_rd_en", int'(rd_en), 0);
    chk("async_rst_value", int'(val), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (16) @(negedge clk);

    // Next trigger after the aborted job completes normally
    run_job(4'b1000, 10, 32, 3, 0, 100, 1'b0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
